// File: rtl/ktms_afu_pkg.sv
// Shared widths, capability field map and table FSM encoding for the AFU
// capability path.
package ktms_afu_pkg;

  localparam int CTXTID_WIDTH  = 10;
  localparam int CTXTCAP_WIDTH = 7;
  localparam int TAG_WIDTH     = 8;

  // cpc dword bit positions that feed cap[0]..cap[6]
  localparam int CAP_SRC_B0 = 0;
  localparam int CAP_SRC_B1 = 1;
  localparam int CAP_SRC_B2 = 3;
  localparam int CAP_SRC_B3 = 60;
  localparam int CAP_SRC_B4 = 61;
  localparam int CAP_SRC_B5 = 62;
  localparam int CAP_SRC_B6 = 63;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } cap_tbl_st_e;

  function automatic logic [CTXTCAP_WIDTH-1:0] cap_from_cpc(input logic [63:0] dw);
    return {dw[CAP_SRC_B6], dw[CAP_SRC_B5], dw[CAP_SRC_B4], dw[CAP_SRC_B3],
            dw[CAP_SRC_B2], dw[CAP_SRC_B1], dw[CAP_SRC_B0]};
  endfunction

endpackage

// File: rtl/ktms_cap_tbl_mem.sv
// 1W1R synchronous capability RAM; a same-address write in the read cycle is
// forwarded into the read register (write-first).
module ktms_cap_tbl_mem #(
  parameter int addr_width = 9,
  parameter int data_width = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en_i,
  input  logic [addr_width-1:0] wr_addr_i,
  input  logic [data_width-1:0] wr_data_i,
  input  logic                  rd_en_i,
  input  logic [addr_width-1:0] rd_addr_i,
  output logic [data_width-1:0] rd_data_o
);

  logic [data_width-1:0] mem_q [2**addr_width];
  logic [data_width-1:0] rd_q;

  // array contents are cleared by the owner's init sweep, not by reset
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
    end else if (rd_en_i) begin
      rd_q <= (wr_en_i && (wr_addr_i == rd_addr_i)) ? wr_data_i : mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/ktms_afu_cap_tbl.sv
// Per-context capability table: zero-fill sweep after reset, parity-checked
// capability writes, and a one-deep valid/ready lookup pipeline.
module ktms_afu_cap_tbl
  import ktms_afu_pkg::*;
#(
  parameter int ctxtid_width  = CTXTID_WIDTH,
  parameter int ctxtcap_width = CTXTCAP_WIDTH,
  parameter int tag_width     = TAG_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_cap_wr_v,
  input  logic [ctxtid_width-1:0]  i_cap_wr_ctxt,
  input  logic [ctxtcap_width-1:0] i_cap_wr_d,
  input  logic                     i_lkp_v,
  output logic                     o_lkp_r,
  input  logic [ctxtid_width-1:0]  i_lkp_ctxt,
  input  logic [tag_width-1:0]     i_lkp_tag,
  output logic                     o_rsp_v,
  input  logic                     i_rsp_r,
  output logic [tag_width-1:0]     o_rsp_tag,
  output logic [ctxtcap_width-1:0] o_rsp_cap,
  output logic                     o_rsp_ctxt_err,
  output logic                     o_init_done,
  output logic [1:0]               o_perror
);

  localparam int idx_width = ctxtid_width - 1;

  cap_tbl_st_e              state_q, state_d;
  logic [idx_width-1:0]     ptr_q, ptr_d;
  logic                     s1_v_q, s1_v_d;
  logic [tag_width-1:0]     tag_q, tag_d;
  logic                     err_q, err_d;
  logic [1:0]               perror_q, perror_d;

  logic                     run;
  logic                     lkp_acc;
  logic                     wr_par_ok;
  logic                     lkp_par_ok;
  logic                     mem_we;
  logic [idx_width-1:0]     mem_waddr;
  logic [ctxtcap_width-1:0] mem_wdata;
  logic [ctxtcap_width-1:0] mem_rdata;

  // odd parity: a good context id has an odd number of ones including the lsb
  assign wr_par_ok  = ^i_cap_wr_ctxt;
  assign lkp_par_ok = ^i_lkp_ctxt;

  assign run     = (state_q == ST_RUN);
  assign o_lkp_r = run & (~s1_v_q | i_rsp_r);
  assign lkp_acc = i_lkp_v & o_lkp_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_INIT;
      ptr_q    <= '0;
      s1_v_q   <= 1'b0;
      tag_q    <= '0;
      err_q    <= 1'b0;
      perror_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      s1_v_q   <= s1_v_d;
      tag_q    <= tag_d;
      err_q    <= err_d;
      perror_q <= perror_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    mem_we    = 1'b0;
    mem_waddr = i_cap_wr_ctxt[ctxtid_width-1:1];
    mem_wdata = i_cap_wr_d;
    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = '0;
        ptr_d     = ptr_q + 1'b1;
        if (&ptr_q) state_d = ST_RUN;
      end
      ST_RUN: begin
        mem_we = i_cap_wr_v & wr_par_ok;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    s1_v_d   = s1_v_q;
    tag_d    = tag_q;
    err_d    = err_q;
    perror_d = perror_q;
    if (lkp_acc) begin
      s1_v_d = 1'b1;
      tag_d  = i_lkp_tag;
      err_d  = ~lkp_par_ok;
    end else if (i_rsp_r) begin
      s1_v_d = 1'b0;
    end
    if (i_cap_wr_v & ~run) perror_d[1] = 1'b1;
    if ((i_cap_wr_v & run & ~wr_par_ok) | (lkp_acc & ~lkp_par_ok)) perror_d[0] = 1'b1;
  end

  ktms_cap_tbl_mem #(
    .addr_width (idx_width),
    .data_width (ctxtcap_width)
  ) u_mem (
    .clk       (clk),
    .rst_n     (reset),
    .wr_en_i   (mem_we),
    .wr_addr_i (mem_waddr),
    .wr_data_i (mem_wdata),
    .rd_en_i   (lkp_acc),
    .rd_addr_i (i_lkp_ctxt[ctxtid_width-1:1]),
    .rd_data_o (mem_rdata)
  );

  assign o_rsp_v        = s1_v_q;
  assign o_rsp_tag      = tag_q;
  assign o_rsp_ctxt_err = err_q;
  assign o_rsp_cap      = err_q ? '0 : mem_rdata;
  assign o_init_done    = run;
  assign o_perror       = perror_q;

endmodule

// File: tb/tb_ktms_afu_cap_tbl.sv
// Directed bench for the capability table: vector table for single-cycle
// lookups, hand sequences for init, back-pressure and reset mid-stream.
module tb_ktms_afu_cap_tbl;

  logic       clk;
  logic       reset;
  logic       i_cap_wr_v;
  logic [9:0] i_cap_wr_ctxt;
  logic [6:0] i_cap_wr_d;
  logic       i_lkp_v;
  logic       o_lkp_r;
  logic [9:0] i_lkp_ctxt;
  logic [7:0] i_lkp_tag;
  logic       o_rsp_v;
  logic       i_rsp_r;
  logic [7:0] o_rsp_tag;
  logic [6:0] o_rsp_cap;
  logic       o_rsp_ctxt_err;
  logic       o_init_done;
  logic [1:0] o_perror;

  int n_chk;
  int n_fail;

  ktms_afu_cap_tbl dut (
    .clk            (clk),
    .reset          (reset),
    .i_cap_wr_v     (i_cap_wr_v),
    .i_cap_wr_ctxt  (i_cap_wr_ctxt),
    .i_cap_wr_d     (i_cap_wr_d),
    .i_lkp_v        (i_lkp_v),
    .o_lkp_r        (o_lkp_r),
    .i_lkp_ctxt     (i_lkp_ctxt),
    .i_lkp_tag      (i_lkp_tag),
    .o_rsp_v        (o_rsp_v),
    .i_rsp_r        (i_rsp_r),
    .o_rsp_tag      (o_rsp_tag),
    .o_rsp_cap      (o_rsp_cap),
    .o_rsp_ctxt_err (o_rsp_ctxt_err),
    .o_init_done    (o_init_done),
    .o_perror       (o_perror)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       wr_v;
    logic [8:0] wr_idx;
    logic       wr_bad;
    logic [6:0] wr_d;
    logic       lkp_v;
    logic [8:0] lkp_idx;
    logic       lkp_bad;
    logic [7:0] tag;
    logic       exp_v;
    logic [6:0] exp_cap;
    logic       exp_err;
  } vec_t;

  vec_t tbl [12];

  // odd parity over the full id; bad=1 flips the parity bit
  function automatic logic [9:0] mk(input logic [8:0] idx, input logic bad);
    return {idx, (~(^idx)) ^ bad};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_cap_wr_v    = 1'b0;
    i_cap_wr_ctxt = '0;
    i_cap_wr_d    = '0;
    i_lkp_v       = 1'b0;
    i_lkp_ctxt    = '0;
    i_lkp_tag     = '0;
    i_rsp_r       = 1'b1;
  endtask

  // called just after reset is released, away from an edge
  task automatic run_init(input bit pulse);
    int cyc;
    cyc = 0;
    for (int c = 1; c <= 600; c++) begin
      i_cap_wr_v    = pulse && (c == 10);
      i_cap_wr_ctxt = mk(9'd5, 1'b0);
      i_cap_wr_d    = 7'h7f;
      if (c == 100) chk("init_lkp_r", {31'd0, o_lkp_r}, 32'd0);
      @(posedge clk);
      #1;
      if (o_init_done) begin
        cyc = c;
        break;
      end
    end
    i_cap_wr_v = 1'b0;
    chk("init_cycles", cyc, 32'd512);
  endtask

  task automatic chk_rsp(input string nm, input logic [6:0] cap, input logic [7:0] tag, input logic err);
    chk({nm, "_v"}, {31'd0, o_rsp_v}, 32'd1);
    chk({nm, "_cap"}, {25'd0, o_rsp_cap}, {25'd0, cap});
    chk({nm, "_tag"}, {24'd0, o_rsp_tag}, {24'd0, tag});
    chk({nm, "_err"}, {31'd0, o_rsp_ctxt_err}, {31'd0, err});
  endtask

  initial begin
    logic [7:0] exp_q [$];
    int sent;
    int got;
    logic acc;
    logic ret;

    n_chk  = 0;
    n_fail = 0;
    idle_inputs();
    reset = 1'b0;
    #2;
    chk("rst_lkp_r", {31'd0, o_lkp_r}, 32'd0);
    chk("rst_rsp_v", {31'd0, o_rsp_v}, 32'd0);
    chk("rst_tag", {24'd0, o_rsp_tag}, 32'd0);
    chk("rst_cap", {25'd0, o_rsp_cap}, 32'd0);
    chk("rst_err", {31'd0, o_rsp_ctxt_err}, 32'd0);
    chk("rst_init_done", {31'd0, o_init_done}, 32'd0);
    chk("rst_perror", {30'd0, o_perror}, 32'd0);

    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    run_init(1'b1);
    chk("init_drop_perror", {30'd0, o_perror}, 32'd2);

    tbl[0]  = '{1'b0, 9'd0,   1'b0, 7'h00, 1'b1, 9'd5,   1'b0, 8'h01, 1'b1, 7'h00, 1'b0};
    tbl[1]  = '{1'b1, 9'd5,   1'b0, 7'h55, 1'b0, 9'd0,   1'b0, 8'h00, 1'b0, 7'h00, 1'b0};
    tbl[2]  = '{1'b0, 9'd0,   1'b0, 7'h00, 1'b1, 9'd5,   1'b0, 8'h02, 1'b1, 7'h55, 1'b0};
    tbl[3]  = '{1'b1, 9'd9,   1'b0, 7'h12, 1'b1, 9'd9,   1'b0, 8'h03, 1'b1, 7'h12, 1'b0};
    tbl[4]  = '{1'b1, 9'd9,   1'b0, 7'h34, 1'b1, 9'd5,   1'b0, 8'h04, 1'b1, 7'h55, 1'b0};
    tbl[5]  = '{1'b0, 9'd0,   1'b0, 7'h00, 1'b1, 9'd9,   1'b0, 8'h05, 1'b1, 7'h34, 1'b0};
    tbl[6]  = '{1'b1, 9'd511, 1'b0, 7'h7f, 1'b1, 9'd0,   1'b0, 8'h06, 1'b1, 7'h00, 1'b0};
    tbl[7]  = '{1'b0, 9'd0,   1'b0, 7'h00, 1'b1, 9'd511, 1'b0, 8'h07, 1'b1, 7'h7f, 1'b0};
    tbl[8]  = '{1'b0, 9'd0,   1'b0, 7'h00, 1'b1, 9'd5,   1'b1, 8'hA5, 1'b1, 7'h00, 1'b1};
    tbl[9]  = '{1'b1, 9'd3,   1'b1, 7'h11, 1'b0, 9'd0,   1'b0, 8'h00, 1'b0, 7'h00, 1'b0};
    tbl[10] = '{1'b0, 9'd0,   1'b0, 7'h00, 1'b1, 9'd3,   1'b0, 8'h0A, 1'b1, 7'h00, 1'b0};
    tbl[11] = '{1'b0, 9'd0,   1'b0, 7'h00, 1'b0, 9'd0,   1'b0, 8'h00, 1'b0, 7'h00, 1'b0};

    for (int i = 0; i < 12; i++) begin
      i_cap_wr_v    = tbl[i].wr_v;
      i_cap_wr_ctxt = mk(tbl[i].wr_idx, tbl[i].wr_bad);
      i_cap_wr_d    = tbl[i].wr_d;
      i_lkp_v       = tbl[i].lkp_v;
      i_lkp_ctxt    = mk(tbl[i].lkp_idx, tbl[i].lkp_bad);
      i_lkp_tag     = tbl[i].tag;
      i_rsp_r       = 1'b1;
      #1;
      chk($sformatf("vec%0d_lkp_r", i), {31'd0, o_lkp_r}, 32'd1);
      @(posedge clk);
      #1;
      if (tbl[i].exp_v) chk_rsp($sformatf("vec%0d", i), tbl[i].exp_cap, tbl[i].tag, tbl[i].exp_err);
      else chk($sformatf("vec%0d_v", i), {31'd0, o_rsp_v}, 32'd0);
    end
    chk("perror_after_tbl", {30'd0, o_perror}, 32'd3);

    // write-first bypass, then a held response under back-pressure
    i_cap_wr_v = 1'b1; i_cap_wr_ctxt = mk(9'd9, 1'b0); i_cap_wr_d = 7'h12;
    i_lkp_v = 1'b1; i_lkp_ctxt = mk(9'd9, 1'b0); i_lkp_tag = 8'h20; i_rsp_r = 1'b1;
    @(posedge clk); #1;
    chk_rsp("hold_a", 7'h12, 8'h20, 1'b0);
    i_rsp_r = 1'b0; i_cap_wr_d = 7'h34;
    i_lkp_ctxt = mk(9'd5, 1'b0); i_lkp_tag = 8'h21;
    #1;
    chk("hold_lkp_r", {31'd0, o_lkp_r}, 32'd0);
    @(posedge clk); #1;
    chk_rsp("hold_b", 7'h12, 8'h20, 1'b0);
    i_cap_wr_v = 1'b0;
    @(posedge clk); #1;
    chk_rsp("hold_c", 7'h12, 8'h20, 1'b0);
    i_rsp_r = 1'b1;
    #1;
    chk("release_lkp_r", {31'd0, o_lkp_r}, 32'd1);
    @(posedge clk); #1;
    chk_rsp("hold_d", 7'h55, 8'h21, 1'b0);
    i_lkp_ctxt = mk(9'd9, 1'b0); i_lkp_tag = 8'h22;
    @(posedge clk); #1;
    chk_rsp("hold_e", 7'h34, 8'h22, 1'b0);
    i_lkp_v = 1'b0;
    @(posedge clk); #1;
    chk("hold_f_v", {31'd0, o_rsp_v}, 32'd0);
    chk("perror_sticky", {30'd0, o_perror}, 32'd3);

    // streamed lookups with random stalls, reset asserted mid-stream
    sent = 0;
    got  = 0;
    for (int c = 0; c < 40; c++) begin
      if (c == 12) begin
        chk("stream_accounting", got + exp_q.size(), sent);
        #2;
        reset = 1'b0;
        #1;
        chk("stream_rst_rsp_v", {31'd0, o_rsp_v}, 32'd0);
        chk("stream_rst_lkp_r", {31'd0, o_lkp_r}, 32'd0);
        chk("stream_rst_init_done", {31'd0, o_init_done}, 32'd0);
        chk("stream_rst_perror", {30'd0, o_perror}, 32'd0);
        break;
      end
      i_lkp_v    = (sent < 16);
      i_lkp_ctxt = mk(9'd5, 1'b0);
      i_lkp_tag  = 8'h40 + 8'(sent);
      i_rsp_r    = 1'($urandom_range(0, 1));
      #1;
      acc = i_lkp_v & o_lkp_r;
      ret = o_rsp_v & i_rsp_r;
      if (ret) begin
        if (exp_q.size() == 0) chk("stream_spurious", 32'd1, 32'd0);
        else chk("stream_tag", {24'd0, o_rsp_tag}, {24'd0, exp_q.pop_front()});
        chk("stream_cap", {25'd0, o_rsp_cap}, 32'h55);
        got++;
      end
      if (acc) begin
        exp_q.push_back(i_lkp_tag);
        sent++;
      end
      @(posedge clk);
      #1;
    end
    chk("stream_progress", {31'd0, sent > 0}, 32'd1);

    idle_inputs();
    @(posedge clk);
    #3;
    reset = 1'b1;
    run_init(1'b0);
    i_lkp_v = 1'b1; i_lkp_ctxt = mk(9'd5, 1'b0); i_lkp_tag = 8'h77;
    @(posedge clk); #1;
    chk_rsp("post_reinit", 7'h00, 8'h77, 1'b0);
    i_lkp_v = 1'b0;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
